// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash command sequencer.
// Holds the op codes, flash opcodes, master commtype encodings and the sequencer state set.
package spi_flash_pkg;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_PROGRAM = 2'b01,
        OP_ERASE   = 2'b10,
        OP_READ_ID = 2'b11
    } op_e;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_PP   = 8'h02;
    localparam logic [7:0] CMD_SE   = 8'h20;
    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_RDSR = 8'h05;
    localparam logic [7:0] CMD_RDID = 8'h9F;

    localparam logic [2:0] CT_CMD     = 3'b000;
    localparam logic [2:0] CT_CMD_RD  = 3'b001;
    localparam logic [2:0] CT_ADDR_RD = 3'b010;
    localparam logic [2:0] CT_ADDR_WR = 3'b100;
    localparam logic [2:0] CT_ADDR    = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WREN_ISS,
        ST_WREN_WAIT,
        ST_OP_ISS,
        ST_OP_WAIT,
        ST_POLL_ISS,
        ST_POLL_WAIT,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic [7:0] cmd;
        logic [2:0] ctype;
        logic [6:0] nmiso;
    } xfer_t;

    // Field set of the "main" transaction for each high-level op.
    function automatic xfer_t op_xfer(input op_e op);
        xfer_t x;
        case (op)
            OP_READ:    x = '{cmd: CMD_READ, ctype: CT_ADDR_RD, nmiso: 7'd32};
            OP_PROGRAM: x = '{cmd: CMD_PP,   ctype: CT_ADDR_WR, nmiso: 7'd0};
            OP_ERASE:   x = '{cmd: CMD_SE,   ctype: CT_ADDR,    nmiso: 7'd0};
            OP_READ_ID: x = '{cmd: CMD_RDID, ctype: CT_CMD_RD,  nmiso: 7'd24};
            default:    x = '0;
        endcase
        return x;
    endfunction

endpackage

// File: rtl/spi_flash_seq_sync2.sv
// Two-flop synchronizer for single-bit handshake signals from the sclk domain.
// RST_VAL lets idle-high signals such as tready come out of reset at their idle level.
module spi_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/spi_flash_seq.sv
// Expands one CPU flash op into WREN / op / RDSR-poll transactions on spi_master_fl
// and returns read data, final status or a timeout error.
module spi_flash_seq
    import spi_flash_pkg::*;
#(
    parameter int unsigned POLL_MAX    = 1023,
    parameter int unsigned ACK_TIMEOUT = 4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [23:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] m_data_in,
    output logic [31:0] m_address,
    output logic [7:0]  m_command,
    output logic [2:0]  m_commtype,
    output logic [6:0]  m_nmiso_bits,
    output logic        m_validflag,
    input  logic [31:0] m_data_out,
    input  logic        m_validflag_out,
    input  logic        m_tready
);

    localparam logic [9:0]  POLL_LIM = 10'(POLL_MAX);
    localparam logic [11:0] TMO_LIM  = 12'(ACK_TIMEOUT - 1);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [23:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [9:0]  poll_cnt_q, poll_cnt_d;
    logic [11:0] tmo_cnt_q, tmo_cnt_d;
    logic        got_ans_q, got_ans_d;
    logic        vo_prev_q;
    logic        ready_q;

    logic        tr_s, vo_s;
    logic        is_iss, is_wait, iss_go, wait_done, tmo_hit, vo_rise, is_pe, wip;
    xfer_t       cur_x;

    spi_sync2 #(.RST_VAL(1'b1)) u_sync_tready (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (m_tready),
        .q     (tr_s)
    );

    spi_sync2 #(.RST_VAL(1'b0)) u_sync_vo (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (m_validflag_out),
        .q     (vo_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_READ;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            poll_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            got_ans_q  <= 1'b0;
            vo_prev_q  <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            poll_cnt_q <= poll_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            got_ans_q  <= got_ans_d;
            vo_prev_q  <= vo_s;
            ready_q    <= 1'b1;
        end
    end

    always_comb begin
        case (state_q)
            ST_WREN_ISS, ST_WREN_WAIT: cur_x = '{cmd: CMD_WREN, ctype: CT_CMD, nmiso: 7'd0};
            ST_OP_ISS, ST_OP_WAIT:     cur_x = op_xfer(op_q);
            ST_POLL_ISS, ST_POLL_WAIT: cur_x = '{cmd: CMD_RDSR, ctype: CT_CMD_RD, nmiso: 7'd8};
            default:                   cur_x = '0;
        endcase
    end

    assign is_iss  = (state_q == ST_WREN_ISS) || (state_q == ST_OP_ISS) || (state_q == ST_POLL_ISS);
    assign is_wait = (state_q == ST_WREN_WAIT) || (state_q == ST_OP_WAIT) || (state_q == ST_POLL_WAIT);
    assign vo_rise = vo_s & ~vo_prev_q;
    assign iss_go  = is_iss & ~tr_s;
    // The nonzero dwell keeps m_validflag low for at least two cycles between transactions.
    assign wait_done = is_wait && tr_s && (got_ans_q || (cur_x.nmiso == '0)) && (tmo_cnt_q != '0);
    assign tmo_hit = (is_iss || is_wait) && (tmo_cnt_q >= TMO_LIM);
    assign is_pe   = (op_q == OP_PROGRAM) || (op_q == OP_ERASE);
    // Master stores MISO LSB-index-first, so status bit0 (WIP) lands in bit 7.
    assign wip     = m_data_out[7];

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        poll_cnt_d = poll_cnt_q;
        got_ans_d  = got_ans_q;

        if (vo_rise) begin
            got_ans_d = 1'b1;
        end else if (iss_go) begin
            got_ans_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    op_d       = op_e'(req_op);
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    err_d      = 1'b0;
                    poll_cnt_d = '0;
                    state_d    = ((req_op == OP_PROGRAM) || (req_op == OP_ERASE)) ? ST_WREN_ISS : ST_OP_ISS;
                end
            end
            ST_WREN_ISS:  if (iss_go) state_d = ST_WREN_WAIT;
            ST_WREN_WAIT: if (wait_done) state_d = ST_OP_ISS;
            ST_OP_ISS:    if (iss_go) state_d = ST_OP_WAIT;
            ST_OP_WAIT: begin
                if (wait_done) begin
                    if (is_pe) begin
                        state_d = ST_POLL_ISS;
                    end else begin
                        rdata_d = (op_q == OP_READ_ID) ? {8'h00, m_data_out[23:0]} : m_data_out;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_POLL_ISS:  if (iss_go) state_d = ST_POLL_WAIT;
            ST_POLL_WAIT: begin
                if (wait_done) begin
                    rdata_d = m_data_out;
                    if (poll_cnt_q != '1) begin
                        poll_cnt_d = poll_cnt_q + 10'd1;
                    end
                    if (wip && (poll_cnt_d < POLL_LIM)) begin
                        state_d = ST_POLL_ISS;
                    end else begin
                        err_d   = wip;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (tmo_hit && (state_d == state_q)) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
        end

        tmo_cnt_d = ((state_d != state_q) || (state_q == ST_IDLE)) ? '0 : tmo_cnt_q + 12'd1;
    end

    always_comb begin
        req_ready    = ready_q && (state_q == ST_IDLE);
        rsp_valid    = (state_q == ST_RESP);
        rsp_rdata    = rdata_q;
        rsp_err      = err_q;
        m_validflag  = is_iss;
        m_command    = cur_x.cmd;
        m_commtype   = cur_x.ctype;
        m_nmiso_bits = cur_x.nmiso;
        m_address    = {8'h00, addr_q};
        m_data_in    = wdata_q;
    end

endmodule

// File: doc/spi_flash_seq.md
# spi_flash_seq

Command sequencer in front of the SPI flash master (`spi_master_fl`). It accepts one high-level flash operation at a time from the CPU-side controller and expands it into the required SPI transactions: write-enable, the operation itself, and status polling until the write-in-progress bit clears. It drives the master's valid/tready/validflag_out handshake and returns read data or an error to the requester.

## Interface
- `POLL_MAX`, 1023: max RDSR polls after PROGRAM/ERASE before error.
- `ACK_TIMEOUT`, 4095: max `clk` cycles waiting for master acceptance (sync'd `m_tready` low) or completion.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: operation request.
- `req_ready` out 1: high only in IDLE; request accepted when `req_valid & req_ready`.
- `req_op` in 2: 00 READ, 01 PROGRAM, 10 SECTOR_ERASE, 11 READ_ID.
- `req_addr` in 24: flash byte address.
- `req_wdata` in 32: program data.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: read/ID data; held until next `rsp_valid`.
- `rsp_err` out 1: timeout flag, qualified by `rsp_valid`.
- `m_data_in` out 32, `m_address` out 32, `m_command` out 8, `m_commtype` out 3, `m_nmiso_bits` out 7, `m_validflag` out 1: master request side.
- `m_data_out` in 32, `m_validflag_out` in 1, `m_tready` in 1: master response side (sclk domain).

## Operation
- Reset values: `req_ready`=0 during reset then 1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `m_validflag`=0, all `m_*` data outputs 0, state IDLE.
- `m_tready`, `m_validflag_out` pass through 2-flop synchronizers (`tr_s`, `vo_s`); `vo_s` rising edge sets sticky `got_ans`.
- Op expansion (cmd, commtype, nmiso): READ: 0x03/010/32. READ_ID: 0x9F/001/24. PROGRAM: WREN 0x06/000, then 0x02/100 with `req_wdata`, then poll. SECTOR_ERASE: WREN, then 0x20/101, then poll. Poll: RDSR 0x05/001/8.
- `m_address` = {8'h00, req_addr}; request fields latched at acceptance and held stable for the whole op.
- States: IDLE -> (WREN_ISS if PROGRAM/ERASE else OP_ISS). X_ISS: `m_validflag`=1, drive transaction fields; on `tr_s`==0 -> X_WAIT, drop `m_validflag`, clear `got_ans`. X_WAIT: done when `tr_s`==1 and (`got_ans` or no answer expected). WREN_WAIT -> OP_ISS; OP_WAIT -> POLL_ISS (PROGRAM/ERASE) or RESP; POLL_WAIT -> capture status; WIP = `m_data_out[7]` (master stores MISO LSB-index-first, so SR bit0 lands in bit 7); WIP=1 and polls<POLL_MAX -> POLL_ISS, else RESP. RESP: `rsp_valid`=1 one cycle -> IDLE.
- READ/READ_ID: `rsp_rdata` = `m_data_out` sampled in OP_WAIT on completion (READ_ID upper 8 bits zero). PROGRAM/ERASE: `rsp_rdata` = last status word.
- Errors: WIP still 1 after POLL_MAX polls, or any ISS/WAIT state exceeding ACK_TIMEOUT -> RESP with `rsp_err`=1, `m_validflag` forced 0.
- `req_valid` while busy is ignored (no queueing). Reset mid-op: immediate IDLE, no resume; master must be reset with it.

## Timing
- Accept -> `m_validflag` high: 1 cycle.
- `m_validflag` deasserts the cycle after `tr_s` sampled low (≥3 cycles after master drops tready).
- Completion detect: 2 cycles after master `tready`/`validflag_out` rise; RESP the following cycle.
- `m_validflag` low ≥2 cycles between consecutive transactions (master needs a fresh rising edge).
- Poll counter 10 bits, saturating; timeout counter 12 bits, cleared on every state change.

## Structure
- Package `spi_flash_pkg`: op codes, flash command constants (0x03, 0x02, 0x20, 0x06, 0x05, 0x9F), commtype encodings, state enum.
- Sub-module `spi_sync2`: 2-flop synchronizer, instantiated for `m_tready` and `m_validflag_out`.

## Test plan
- READ addr 0x000100, flash model returns 0xDEADBEEF -> one transaction cmd 0x03/commtype 010/nmiso 32, `rsp_rdata`=0xDEADBEEF, `rsp_err`=0.
- READ_ID -> cmd 0x9F, nmiso 24, `rsp_rdata`=0x00EF4018 for model ID EF4018.
- PROGRAM 0x001000 data 0x12345678, WIP busy for 3 polls -> sequence WREN, 0x02, 4× RDSR; `rsp_err`=0.
- SECTOR_ERASE with WIP stuck 1, POLL_MAX=4 -> exactly 4 polls then `rsp_valid` with `rsp_err`=1.
- Master tready never falls, ACK_TIMEOUT=16 -> `rsp_err`=1 after 16 cycles, `m_validflag` 0.
- `rst_n` low in POLL_WAIT -> all outputs at reset values same cycle; `req_valid` during busy produces no extra transaction.
